// File: rtl/riscv_load_store_unit_if.sv
// Request, memory-port and write-back signals of the RISC-V load/store unit.
// master = execute stage plus memory; slave = the LSU itself.
interface riscv_load_store_unit_if #(
   parameter int ADDR_W = 32
);
   // A request transfers on a rising edge where req_valid && req_ready. The master
   // holds req_valid and all req_* fields stable until that edge. It may change them afterwards.
   logic              req_valid;
   logic              req_ready;
   logic              req_store;
   logic [2:0]        req_funct3;
   logic [ADDR_W-1:0] req_addr;
   logic [31:0]       req_wdata;
   logic [4:0]        req_rd;

   logic [ADDR_W-1:0] mem_addr;
   logic              mem_rstrb;
   logic [3:0]        mem_wmask;
   logic [31:0]       mem_wdata;
   logic [31:0]       mem_rdata;
   logic              mem_ack;

   logic              done;
   logic              wb_valid;
   logic [4:0]        wb_rd;
   logic [31:0]       wb_data;
   logic              err;

   modport master (
      output req_valid, req_store, req_funct3, req_addr, req_wdata, req_rd,
      input  req_ready,
      input  mem_addr, mem_rstrb, mem_wmask, mem_wdata,
      output mem_rdata, mem_ack,
      input  done, wb_valid, wb_rd, wb_data, err
   );

   modport slave (
      input  req_valid, req_store, req_funct3, req_addr, req_wdata, req_rd,
      output req_ready,
      output mem_addr, mem_rstrb, mem_wmask, mem_wdata,
      input  mem_rdata, mem_ack,
      output done, wb_valid, wb_rd, wb_data, err
   );
endinterface

// File: rtl/riscv_load_store_unit.sv
// Memory stage: one byte/half/word load or store per request on a word-wide port.
// Define MISALIGN_TRAP_EN to trap misaligned H/W accesses instead of performing them.
module riscv_load_store_unit #(
   parameter int ADDR_W = 32
) (
   input  logic                    clk,
   input  logic                    resetn,
   riscv_load_store_unit_if.slave  bus,
   output logic [1:0]              state_o
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_e;

   state_e            state_q, state_d;
   logic              accept;
   logic              misalign;
   logic              trap_q;
   logic              store_q;
   logic [2:0]        funct3_q;
   logic [1:0]        a_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [31:0]       mem_wdata_q;
   logic [3:0]        wmask_q;
   logic [4:0]        wb_rd_q;
   logic [31:0]       wb_data_q;
   logic [3:0]        lane_mask;
   logic [31:0]       lane_data;
   logic [7:0]        ld_b;
   logic [15:0]       ld_h;
   logic [31:0]       load_ext;

   assign accept  = bus.req_valid && (state_q == IDLE);
   assign state_o = state_q;

`ifdef MISALIGN_TRAP_EN
   always_comb begin
      case (bus.req_funct3[1:0])
         2'b00:   misalign = 1'b0;
         2'b01:   misalign = bus.req_addr[0];
         default: misalign = |bus.req_addr[1:0];
      endcase
   end
`else
   assign misalign = 1'b0;
   assign trap_q   = 1'b0;
`endif

   // Store lanes: data is replicated so any enabled byte lane sees the right value.
   always_comb begin
      lane_mask = 4'b1111;
      lane_data = bus.req_wdata;
      case (bus.req_funct3[1:0])
         2'b00: begin
            lane_mask = 4'b0001 << bus.req_addr[1:0];
            lane_data = {4{bus.req_wdata[7:0]}};
         end
         2'b01: begin
            lane_mask = 4'b0011 << {bus.req_addr[1], 1'b0};
            lane_data = {2{bus.req_wdata[15:0]}};
         end
         default: ;
      endcase
   end

   always_comb begin
      ld_b = bus.mem_rdata[{a_q, 3'b000} +: 8];
      ld_h = bus.mem_rdata[{a_q[1], 4'b0000} +: 16];
      case (funct3_q[1:0])
         2'b00:   load_ext = funct3_q[2] ? {24'd0, ld_b} : {{24{ld_b[7]}}, ld_b};
         2'b01:   load_ext = funct3_q[2] ? {16'd0, ld_h} : {{16{ld_h[15]}}, ld_h};
         default: load_ext = bus.mem_rdata;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d       = state_q;
      bus.req_ready = 1'b0;
      bus.mem_rstrb = 1'b0;
      bus.mem_wmask = 4'b0000;
      bus.done      = 1'b0;
      bus.wb_valid  = 1'b0;
      bus.err       = 1'b0;
      case (state_q)
         IDLE: begin
            bus.req_ready = 1'b1;
            if (bus.req_valid) state_d = misalign ? RESP : ISSUE;
         end
         ISSUE: begin
            bus.mem_rstrb = !store_q;
            bus.mem_wmask = store_q ? wmask_q : 4'b0000;
            state_d       = bus.mem_ack ? RESP : WAIT;
         end
         WAIT: begin
            if (bus.mem_ack) state_d = RESP;
         end
         RESP: begin
            bus.done     = 1'b1;
            bus.wb_valid = !store_q && !trap_q;
            bus.err      = trap_q;
            state_d      = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         store_q     <= 1'b0;
         funct3_q    <= 3'd0;
         a_q         <= 2'd0;
         mem_addr_q  <= '0;
         mem_wdata_q <= 32'd0;
         wmask_q     <= 4'd0;
         wb_rd_q     <= 5'd0;
         wb_data_q   <= 32'd0;
`ifdef MISALIGN_TRAP_EN
         trap_q      <= 1'b0;
`endif
      end else begin
         if (accept) begin
            store_q     <= bus.req_store;
            funct3_q    <= bus.req_funct3;
            a_q         <= bus.req_addr[1:0];
            mem_addr_q  <= {bus.req_addr[ADDR_W-1:2], 2'b00};
            mem_wdata_q <= lane_data;
            wmask_q     <= lane_mask;
            wb_rd_q     <= bus.req_rd;
`ifdef MISALIGN_TRAP_EN
            trap_q      <= misalign;
`endif
         end
         if ((state_q == ISSUE || state_q == WAIT) && bus.mem_ack && !store_q)
            wb_data_q <= load_ext;
      end
   end

   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.wb_rd     = wb_rd_q;
   assign bus.wb_data   = wb_data_q;

endmodule

// File: tb/tb_riscv_load_store_unit.sv
// Directed bench for riscv_load_store_unit: request driver with a small memory
// responder, write-back scoreboard, and a final report.
module tb_riscv_load_store_unit;
   logic       clk;
   logic       resetn;
   logic [1:0] state;
   int         n_checks;
   int         n_errors;
   logic [31:0] exp_q[$];

   riscv_load_store_unit_if #(.ADDR_W(32)) bus();

   riscv_load_store_unit #(.ADDR_W(32)) dut (
      .clk     (clk),
      .resetn  (resetn),
      .bus     (bus),
      .state_o (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Scoreboard: every write-back pulse must match the oldest expected load value.
   always @(negedge clk) begin
      if (resetn && bus.wb_valid) begin
         if (exp_q.size() == 0) check_eq("wb_spurious", {31'd0, bus.wb_valid}, 32'd0);
         else                   check_eq("wb_data", bus.wb_data, exp_q.pop_front());
      end
   end

   int          g_done_cyc, g_rstrb_n, g_wmask_n, g_done_n;
   logic [3:0]  g_wmask;
   logic [31:0] g_maddr, g_mwdata;
   logic        g_stable_ok, g_wbv, g_err;
   logic [4:0]  g_wbrd;

   // Called at a negedge with the DUT idle; returns at a negedge two cycles after done.
   task automatic do_req(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [4:0] rd, input int waits,
                         input logic [31:0] rdata);
      int strobe_c;
      int guard;
      g_done_cyc = -1; g_rstrb_n = 0; g_wmask_n = 0; g_done_n = 0;
      g_wmask = 4'd0; g_maddr = 32'hFFFF_FFFF; g_mwdata = 32'd0;
      g_stable_ok = 1'b1; g_wbv = 1'b0; g_err = 1'b0; g_wbrd = 5'd0;
      bus.req_valid = 1'b1; bus.req_store = st; bus.req_funct3 = f3;
      bus.req_addr = addr; bus.req_wdata = wd; bus.req_rd = rd;
      guard = 0;
      while (!bus.req_ready && guard < 10) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 10) check_eq("accept_timeout", {31'd0, bus.req_ready}, 32'd1);
      @(negedge clk);
      bus.req_valid = 1'b0;
      bus.req_addr  = $urandom;
      bus.req_wdata = $urandom;
      bus.req_rd    = 5'($urandom_range(0, 31));
      strobe_c = -1;
      for (int c = 1; c <= 30; c++) begin
         if (bus.mem_rstrb) begin
            g_rstrb_n++;
            g_maddr = bus.mem_addr;
            if (strobe_c < 0) strobe_c = c;
         end
         if (bus.mem_wmask != 4'd0) begin
            g_wmask_n++;
            g_wmask  = bus.mem_wmask;
            g_maddr  = bus.mem_addr;
            g_mwdata = bus.mem_wdata;
            if (strobe_c < 0) strobe_c = c;
         end
         if (strobe_c > 0 && c > strobe_c && g_done_n == 0 &&
             (bus.mem_addr !== g_maddr || (st && bus.mem_wdata !== g_mwdata)))
            g_stable_ok = 1'b0;
         if (bus.done) begin
            g_done_n++;
            if (g_done_n == 1) begin
               g_done_cyc = c; g_wbv = bus.wb_valid; g_err = bus.err; g_wbrd = bus.wb_rd;
            end
         end
         bus.mem_ack   = (strobe_c > 0 && c == strobe_c + waits && g_done_n == 0);
         bus.mem_rdata = bus.mem_ack ? rdata : $urandom;
         if (g_done_n > 0 && c >= g_done_cyc + 2) break;
         @(negedge clk);
      end
      bus.mem_ack = 1'b0;
      if (g_done_n == 0) check_eq("done_timeout", 32'd0, 32'd1);
   endtask

   task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [4:0] rd, input logic [31:0] rdata, input logic [31:0] exp);
      exp_q.push_back(exp);
      do_req(1'b0, f3, addr, 32'd0, rd, 0, rdata);
      check_eq({tag, "_maddr"}, g_maddr, {addr[31:2], 2'b00});
      check_eq({tag, "_rstrb_n"}, g_rstrb_n, 1);
      check_eq({tag, "_latency"}, g_done_cyc, 2);
      check_eq({tag, "_wbv"}, {31'd0, g_wbv}, 32'd1);
      check_eq({tag, "_wbrd"}, {27'd0, g_wbrd}, {27'd0, rd});
   endtask

   initial begin
      n_checks = 0; n_errors = 0;
      resetn = 1'b0;
      bus.req_valid = 1'b0; bus.req_store = 1'b0; bus.req_funct3 = 3'd0;
      bus.req_addr = 32'd0; bus.req_wdata = 32'd0; bus.req_rd = 5'd0;
      bus.mem_rdata = 32'd0; bus.mem_ack = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("rst_ready", {31'd0, bus.req_ready}, 32'd1);
      check_eq("rst_rstrb", {31'd0, bus.mem_rstrb}, 32'd0);
      check_eq("rst_wmask", {28'd0, bus.mem_wmask}, 32'd0);
      check_eq("rst_maddr", bus.mem_addr, 32'd0);
      check_eq("rst_mwdata", bus.mem_wdata, 32'd0);
      check_eq("rst_done", {31'd0, bus.done}, 32'd0);
      check_eq("rst_wbv", {31'd0, bus.wb_valid}, 32'd0);
      check_eq("rst_wbrd", {27'd0, bus.wb_rd}, 32'd0);
      check_eq("rst_wbdata", bus.wb_data, 32'd0);
      check_eq("rst_err", {31'd0, bus.err}, 32'd0);
      check_eq("rst_state", {30'd0, state}, 32'd0);
      resetn = 1'b1;
      @(negedge clk);

      do_load("lw", 3'b010, 32'h104, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF);
      check_eq("lw_err", {31'd0, g_err}, 32'd0);
      check_eq("lw_done_n", g_done_n, 1);

      do_load("lb", 3'b000, 32'h103, 5'd6, 32'h80112233, 32'hFFFFFF80);
      do_load("lbu", 3'b100, 32'h103, 5'd7, 32'h80112233, 32'h00000080);
      do_load("lhu", 3'b101, 32'h102, 5'd8, 32'h80112233, 32'h00008011);
      do_load("lh_hi", 3'b001, 32'h102, 5'd9, 32'h80112233, 32'hFFFF8011);
      do_load("lh_lo", 3'b001, 32'h100, 5'd10, 32'h80112233, 32'h00002233);
      do_load("lb_1", 3'b000, 32'h101, 5'd11, 32'h80112233, 32'h00000022);
      do_load("lw_f3_11", 3'b011, 32'h208, 5'd12, 32'h13572468, 32'h13572468);

      do_req(1'b1, 3'b001, 32'h22, 32'h0000ABCD, 5'd3, 3, 32'd0);
      check_eq("sh_wmask", {28'd0, g_wmask}, 32'h0000000C);
      check_eq("sh_wmask_n", g_wmask_n, 1);
      check_eq("sh_rstrb_n", g_rstrb_n, 0);
      check_eq("sh_mwdata", g_mwdata, 32'hABCDABCD);
      check_eq("sh_maddr", g_maddr, 32'h20);
      check_eq("sh_stable", {31'd0, g_stable_ok}, 32'd1);
      check_eq("sh_latency", g_done_cyc, 5);
      check_eq("sh_done_n", g_done_n, 1);
      check_eq("sh_wbv", {31'd0, g_wbv}, 32'd0);

      do_req(1'b1, 3'b010, 32'h10, 32'h12345678, 5'd0, 1, 32'd0);
      check_eq("sw_wmask", {28'd0, g_wmask}, 32'h0000000F);
      check_eq("sw_mwdata", g_mwdata, 32'h12345678);
      check_eq("sw_stable", {31'd0, g_stable_ok}, 32'd1);
      check_eq("sw_latency", g_done_cyc, 3);

`ifdef MISALIGN_TRAP_EN
      do_req(1'b0, 3'b010, 32'h102, 32'd0, 5'd9, 0, 32'h11223344);
      check_eq("mis_rstrb_n", g_rstrb_n, 0);
      check_eq("mis_latency", g_done_cyc, 1);
      check_eq("mis_err", {31'd0, g_err}, 32'd1);
      check_eq("mis_wbv", {31'd0, g_wbv}, 32'd0);
      check_eq("mis_done_n", g_done_n, 1);
      do_req(1'b1, 3'b001, 32'h21, 32'h0000BEEF, 5'd0, 0, 32'd0);
      check_eq("mis_sh_wmask_n", g_wmask_n, 0);
      check_eq("mis_sh_err", {31'd0, g_err}, 32'd1);
`else
      do_load("mis_lw", 3'b010, 32'h102, 5'd9, 32'h11223344, 32'h11223344);
      check_eq("mis_lw_err", {31'd0, g_err}, 32'd0);
      do_req(1'b1, 3'b001, 32'h21, 32'h0000BEEF, 5'd0, 0, 32'd0);
      check_eq("mis_sh_wmask", {28'd0, g_wmask}, 32'h00000003);
      check_eq("mis_sh_err", {31'd0, g_err}, 32'd0);
`endif

      // Reset while waiting for a load; the late ack must not produce a response.
      bus.req_valid = 1'b1; bus.req_store = 1'b0; bus.req_funct3 = 3'b010;
      bus.req_addr = 32'h300; bus.req_rd = 5'd7;
      @(negedge clk);
      bus.req_valid = 1'b0;
      check_eq("rs_rstrb", {31'd0, bus.mem_rstrb}, 32'd1);
      @(negedge clk);
      check_eq("rs_state_wait", {30'd0, state}, 32'd2);
      check_eq("rs_rstrb_once", {31'd0, bus.mem_rstrb}, 32'd0);
      resetn = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
      check_eq("rs_ready", {31'd0, bus.req_ready}, 32'd1);
      check_eq("rs_state", {30'd0, state}, 32'd0);
      check_eq("rs_rstrb_off", {31'd0, bus.mem_rstrb}, 32'd0);
      check_eq("rs_done", {31'd0, bus.done}, 32'd0);
      check_eq("rs_maddr", bus.mem_addr, 32'd0);
      bus.mem_ack = 1'b1; bus.mem_rdata = 32'h77777777;
      @(negedge clk);
      bus.mem_ack = 1'b0;
      check_eq("rs_late_done", {31'd0, bus.done}, 32'd0);
      check_eq("rs_late_ready", {31'd0, bus.req_ready}, 32'd1);
      @(negedge clk);
      check_eq("rs_late_done2", {31'd0, bus.done}, 32'd0);

      // req_valid held high across two requests.
      exp_q.push_back(32'hCAFEF00D);
      bus.req_valid = 1'b1; bus.req_store = 1'b0; bus.req_funct3 = 3'b010;
      bus.req_addr = 32'h200; bus.req_rd = 5'd1;
      check_eq("bb_ready0", {31'd0, bus.req_ready}, 32'd1);
      @(negedge clk);
      check_eq("bb_rstrb", {31'd0, bus.mem_rstrb}, 32'd1);
      check_eq("bb_busy1", {31'd0, bus.req_ready}, 32'd0);
      bus.req_store = 1'b1; bus.req_funct3 = 3'b000; bus.req_addr = 32'h1;
      bus.req_wdata = 32'h0000005A; bus.req_rd = 5'd0;
      bus.mem_ack = 1'b1; bus.mem_rdata = 32'hCAFEF00D;
      @(negedge clk);
      bus.mem_ack = 1'b0;
      check_eq("bb_done1", {31'd0, bus.done}, 32'd1);
      check_eq("bb_busy2", {31'd0, bus.req_ready}, 32'd0);
      @(negedge clk);
      check_eq("bb_ready3", {31'd0, bus.req_ready}, 32'd1);
      check_eq("bb_wmask3", {28'd0, bus.mem_wmask}, 32'd0);
      @(negedge clk);
      bus.req_valid = 1'b0;
      check_eq("bb_sb_wmask", {28'd0, bus.mem_wmask}, 32'h00000002);
      check_eq("bb_sb_wdata", bus.mem_wdata, 32'h5A5A5A5A);
      check_eq("bb_sb_maddr", bus.mem_addr, 32'h0);
      bus.mem_ack = 1'b1;
      @(negedge clk);
      bus.mem_ack = 1'b0;
      check_eq("bb_done2", {31'd0, bus.done}, 32'd1);
      check_eq("bb_wbv2", {31'd0, bus.wb_valid}, 32'd0);
      @(negedge clk);
      check_eq("bb_ready_end", {31'd0, bus.req_ready}, 32'd1);

      check_eq("exp_q_empty", exp_q.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
